// File: rtl/mem_byte_sequencer.sv
// Splits 32-bit load/store requests into little-endian byte accesses on a
// byte-wide memory, then returns one response with reassembled, extended data.
module mem_byte_sequencer #(
  parameter bit ALIGN_CHECK = 1'b1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic              wr_q;
  logic              sgn_q;
  logic [1:0]        size_q;
  logic [1:0]        cnt;
  logic              err_q;

  logic              req_err;
  logic [1:0]        last_idx;
  logic [31:0]       ext;

  assign req_err = (req_size == 2'b11) ||
                   (ALIGN_CHECK && ((req_size == 2'b01 && req_addr[0]) ||
                                    (req_size == 2'b10 && req_addr[1:0] != 2'b00)));

  always_comb begin
    case (size_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      buf_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          base    <= req_addr;
          wdata_q <= req_wdata;
          wr_q    <= req_wr;
          size_q  <= req_size;
          sgn_q   <= req_signed;
          cnt     <= 2'd0;
          buf_q   <= 32'd0;
          err_q   <= req_err;
          state   <= req_err ? RESP : XFER;
        end
        XFER: begin
          // Stores leave the buffer at zero so the ack carries rdata=0.
          if (!wr_q) buf_q[{cnt, 3'b000} +: 8] <= mem_rdata;
          cnt <= cnt + 2'd1;
          if (cnt == last_idx) state <= RESP;
        end
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (size_q)
      2'b00:   ext = {{24{sgn_q & buf_q[7]}},  buf_q[7:0]};
      2'b01:   ext = {{16{sgn_q & buf_q[15]}}, buf_q[15:0]};
      default: ext = buf_q;
    endcase
  end

  // Reset gates the strobes so an in-flight write cannot land on the reset edge.
  assign req_ready  = ~rst & (state == IDLE);
  assign resp_valid = ~rst & (state == RESP);
  assign mem_enable = ~rst & (state == XFER);
  assign mem_wr     = mem_enable & wr_q;
  assign mem_addr   = base + ADDR_W'(cnt);
  assign mem_wdata  = (state == XFER && wr_q) ? wdata_q[{cnt, 3'b000} +: 8] : 8'd0;
  assign resp_rdata = (state == RESP) ? ext : 32'd0;
  assign resp_err   = err_q & (state == RESP);

endmodule
